// File: rtl/alu_sequencer.sv
// Multicycle control sequencer: steps fetch/decode/execute states, drives datapath
// strobes combinationally from the current state, and counts retired instructions.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOP,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        EXEC_I    = 4'd9,
        I_WB      = 4'd10,
        TRAP      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ORI = 7'b0010011;

    state_t           state_r;
    state_t           next_s;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;
    logic             retire_s;

    // Next-state selection; unused codes recover to FETCH.
    always_comb begin
        next_s = FETCH;
        case (state_r)
            FETCH:     next_s = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    OP_LD, OP_SD: next_s = MEM_ADDR;
                    OP_R:         next_s = EXEC_R;
                    OP_BEQ:       next_s = BRANCH;
                    OP_ORI:       next_s = EXEC_I;
                    default:      next_s = TRAP;
                endcase
            end
            MEM_ADDR:  next_s = (Opcode == OP_LD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_s = MemReady ? MEM_WB : MEM_READ;
            MEM_WB:    next_s = FETCH;
            MEM_WRITE: next_s = MemReady ? FETCH : MEM_WRITE;
            EXEC_R:    next_s = R_WB;
            R_WB:      next_s = FETCH;
            BRANCH:    next_s = FETCH;
            EXEC_I:    next_s = I_WB;
            I_WB:      next_s = FETCH;
            TRAP:      next_s = TRAP;
            default:   next_s = FETCH;
        endcase
    end

    // An instruction retires on the edge leaving its final state.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            MEM_WB, R_WB, I_WB, BRANCH: retire_s = 1'b1;
            MEM_WRITE:                  retire_s = MemReady;
            default:                    retire_s = 1'b0;
        endcase
    end

    // State, sticky illegal flag and retired counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= FETCH;
            illegal_r <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (next_s == TRAP) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Datapath control decode; combinational so strobes drop the moment reset hits.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        PCSource = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOP    = 3'b000;
        case (state_r)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE:   ALUSrcB = 2'b10;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOP   = 3'b010;
            end
            R_WB:     RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOP    = 3'b001;
                PCSource = 1'b1;
                PCWrite  = Zero;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOP   = 3'b011;
            end
            I_WB:     RegWrite = 1'b1;
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

    assign Illegal = illegal_r;
    assign State   = state_r;
    assign Retired = retired_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: random instruction streams with wait states, checked against
// a per-instruction state-sequence model and the control table for each state.
module tb_alu_sequencer;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_ORI = 7'b0010011;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  Opcode = 7'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;

    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOP;
    logic        Illegal;
    logic [3:0]  State;
    logic [15:0] Retired;

    logic        pcw4, iord4, mrd4, mwr4, irw4, m2r4, rw4, srca4, pcs4;
    logic [1:0]  srcb4;
    logic [2:0]  aluop4;
    logic        ill4;
    logic [3:0]  state4;
    logic [3:0]  ret4;

    logic [13:0] ctrl, ctrl4;
    logic [15:0] ret_model;
    logic        ill_model;
    int          total = 0;
    int          bad = 0;

    assign ctrl  = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                    ALUSrcA, PCSource, ALUSrcB, ALUOP};
    assign ctrl4 = {pcw4, iord4, mrd4, mwr4, irw4, m2r4, rw4, srca4, pcs4, srcb4, aluop4};

    always #5 clock = ~clock;

    alu_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .Illegal(Illegal),
        .State(State), .Retired(Retired)
    );

    alu_sequencer #(.CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(pcw4), .IorD(iord4), .MemRead(mrd4), .MemWrite(mwr4),
        .IRWrite(irw4), .MemtoReg(m2r4), .RegWrite(rw4), .ALUSrcA(srca4),
        .PCSource(pcs4), .ALUSrcB(srcb4), .ALUOP(aluop4), .Illegal(ill4),
        .State(state4), .Retired(ret4)
    );

    // Control word expected in a state, written straight from the per-state strobe list.
    function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z);
        logic pcw, iord, mrd, mwr, irw, m2r, rw, srca, pcs;
        logic [1:0] srcb;
        logic [2:0] op;
        {pcw, iord, mrd, mwr, irw, m2r, rw, srca, pcs} = 9'd0;
        srcb = 2'b00;
        op   = 3'b000;
        case (st)
            4'd0:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  srcb = 2'b10;
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  begin srca = 1'b1; op = 3'b010; end
            4'd7:  rw = 1'b1;
            4'd8:  begin srca = 1'b1; op = 3'b001; pcs = 1'b1; pcw = z; end
            4'd9:  begin srca = 1'b1; srcb = 2'b10; op = 3'b011; end
            4'd10: rw = 1'b1;
            default: op = 3'b000;
        endcase
        return {pcw, iord, mrd, mwr, irw, m2r, rw, srca, pcs, srcb, op};
    endfunction

    // One cycle: drive handshake inputs at the falling edge, check both instances, advance.
    task automatic step(input logic [3:0] es, input logic mr, input logic z);
        logic [13:0] ec;
        MemReady = mr;
        Zero     = z;
        #1;
        ec = exp_ctrl(es, mr, z);
        total++;
        if (State !== es) begin
            bad++; $display("FAIL state: got %0d expected %0d (t=%0t)", State, es, $time);
        end
        total++;
        if (ctrl !== ec) begin
            bad++; $display("FAIL ctrl st=%0d: got %b expected %b", es, ctrl, ec);
        end
        total++;
        if (Retired !== ret_model) begin
            bad++; $display("FAIL retired: got %0d expected %0d", Retired, ret_model);
        end
        total++;
        if (Illegal !== ill_model) begin
            bad++; $display("FAIL illegal: got %b expected %b", Illegal, ill_model);
        end
        total++;
        if (state4 !== es || ctrl4 !== ec || ret4 !== ret_model[3:0] || ill4 !== ill_model) begin
            bad++;
            $display("FAIL cnt4 instance: state=%0d ctrl=%b ret=%0d ill=%b expected %0d %b %0d %b",
                     state4, ctrl4, ret4, ill4, es, ec, ret_model[3:0], ill_model);
        end
        @(negedge clock);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Whole instruction: fw fetch waits, mw memory waits, z is the branch Zero flag.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        Opcode = op;
        for (int i = 0; i < fw; i++) step(4'd0, 1'b0, rbit());
        step(4'd0, 1'b1, rbit());
        step(4'd1, rbit(), rbit());
        case (op)
            OP_LD: begin
                step(4'd2, rbit(), rbit());
                for (int i = 0; i < mw; i++) step(4'd3, 1'b0, rbit());
                step(4'd3, 1'b1, rbit());
                step(4'd4, rbit(), rbit());
            end
            OP_SD: begin
                step(4'd2, rbit(), rbit());
                for (int i = 0; i < mw; i++) step(4'd5, 1'b0, rbit());
                step(4'd5, 1'b1, rbit());
            end
            OP_R: begin
                step(4'd6, rbit(), rbit());
                step(4'd7, rbit(), rbit());
            end
            OP_ORI: begin
                step(4'd9, rbit(), rbit());
                step(4'd10, rbit(), rbit());
            end
            default: step(4'd8, rbit(), z);
        endcase
        ret_model = ret_model + 16'd1;
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase.
    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || Retired !== 16'd0 || Illegal !== 1'b0 || ret4 !== 4'd0) begin
            bad++;
            $display("FAIL reset: state=%0d retired=%0d illegal=%b expected 0 0 0", State, Retired, Illegal);
        end
        total++;
        if (MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: memwrite=%b regwrite=%b expected 0", MemWrite, RegWrite);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        ret_model = 16'd0;
        ill_model = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_R, 1'b1, 2, 0);
    endtask

    task automatic test_load_wait();
        run_instr(OP_LD, 1'b0, 0, 2);
        run_instr(OP_LD, 1'b0, 0, 0);
        run_instr(OP_SD, 1'b0, 1, 3);
    endtask

    task automatic test_branch();
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
    endtask

    task automatic test_trap();
        Opcode = 7'b1111111;
        step(4'd0, 1'b1, 1'b0);
        step(4'd1, rbit(), rbit());
        ill_model = 1'b1;
        for (int i = 0; i < 10; i++) step(4'd11, rbit(), rbit());
        test_reset();
    endtask

    task automatic test_reset_midwrite();
        run_instr(OP_ORI, 1'b0, 0, 0);
        run_instr(OP_R, 1'b0, 0, 0);
        Opcode = OP_SD;
        step(4'd0, 1'b1, 1'b0);
        step(4'd1, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0);
        MemReady = 1'b0;
        test_reset();
        run_instr(OP_R, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 16; i++) run_instr(OP_ORI, 1'b0, i % 2, 0);
        #1;
        total++;
        if (ret4 !== 4'd0 || Retired !== 16'd16) begin
            bad++; $display("FAIL wrap: cnt4=%0d cnt16=%0d expected 0 16", ret4, Retired);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [5];
        ops[0] = OP_LD; ops[1] = OP_SD; ops[2] = OP_R; ops[3] = OP_BEQ; ops[4] = OP_ORI;
        for (int i = 0; i < 40; i++) begin
            run_instr(ops[$urandom_range(0, 4)], rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        ret_model = 16'd0;
        ill_model = 1'b0;
        @(negedge clock);
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_reset_midwrite();
        test_trap();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
